// File: rtl/pe_dot_sat_if.sv
// Operand, enable and drain-chain signals of one pe_dot_sat tile.
// The array side uses master; the PE uses slave.
interface pe_dot_sat_if #(
  parameter int D_W     = 8,
  parameter int D_W_ACC = 32,
  parameter int LANES   = 2
);
  logic                   init;
  logic                   in_en;
  logic [LANES*D_W-1:0]   in_a;
  logic [LANES*D_W-1:0]   in_b;
  logic [D_W_ACC-1:0]     in_data;
  logic                   in_valid;
  logic                   in_ovf;
  logic [LANES*D_W-1:0]   out_a;
  logic [LANES*D_W-1:0]   out_b;
  logic                   out_en;
  logic [D_W_ACC-1:0]     out_data;
  logic                   out_valid;
  logic                   out_ovf;

  modport master (
    output init, in_en, in_a, in_b, in_data, in_valid, in_ovf,
    input  out_a, out_b, out_en, out_data, out_valid, out_ovf
  );

  modport slave (
    input  init, in_en, in_a, in_b, in_data, in_valid, in_ovf,
    output out_a, out_b, out_en, out_data, out_valid, out_ovf
  );
endinterface

// File: rtl/pe_dot_sat.sv
// Systolic PE: multi-lane dot-product MAC with a registered product stage,
// optional saturating accumulation and a 2-stage result drain chain.
module pe_dot_sat #(
  parameter int D_W     = 8,
  parameter int D_W_ACC = 32,
  parameter int LANES   = 2,
  parameter int SAT     = 1,
  parameter int SIGNED  = 1
) (
  input logic         clk,
  input logic         rst,
  pe_dot_sat_if.slave bus
);

  localparam logic [D_W_ACC-1:0] ACC_MAX =
    (SIGNED != 0) ? {1'b0, {(D_W_ACC-1){1'b1}}} : {D_W_ACC{1'b1}};
  localparam logic [D_W_ACC-1:0] ACC_MIN =
    (SIGNED != 0) ? {1'b1, {(D_W_ACC-1){1'b0}}} : {D_W_ACC{1'b0}};

  logic [D_W-1:0]     lane_a, lane_b;
  logic [D_W_ACC-1:0] ext_a, ext_b;
  logic [D_W_ACC-1:0] dot;

  logic [D_W_ACC-1:0] prod_r;
  logic               init_r, en_r;
  logic [D_W_ACC-1:0] acc;
  logic               ovf;

  logic [D_W_ACC-1:0] chain_data;
  logic               chain_valid, chain_ovf;

  logic [D_W_ACC:0]   sum_w;
  logic               sum_ovf;
  logic [D_W_ACC-1:0] acc_sum;

  // Lanes are widened to the accumulator width before multiplying; the
  // low D_W_ACC bits of the sum equal the extended exact dot product.
  always_comb begin
    dot    = '0;
    lane_a = '0;
    lane_b = '0;
    ext_a  = '0;
    ext_b  = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_a = bus.in_a[i*D_W +: D_W];
      lane_b = bus.in_b[i*D_W +: D_W];
      if (SIGNED != 0) begin
        ext_a = {{(D_W_ACC-D_W){lane_a[D_W-1]}}, lane_a};
        ext_b = {{(D_W_ACC-D_W){lane_b[D_W-1]}}, lane_b};
      end else begin
        ext_a = {{(D_W_ACC-D_W){1'b0}}, lane_a};
        ext_b = {{(D_W_ACC-D_W){1'b0}}, lane_b};
      end
      dot = dot + ext_a * ext_b;
    end
  end

  always_comb begin
    if (SIGNED != 0) begin
      sum_w   = {acc[D_W_ACC-1], acc} + {prod_r[D_W_ACC-1], prod_r};
      sum_ovf = sum_w[D_W_ACC] ^ sum_w[D_W_ACC-1];
    end else begin
      sum_w   = {1'b0, acc} + {1'b0, prod_r};
      sum_ovf = sum_w[D_W_ACC];
    end
    acc_sum = sum_w[D_W_ACC-1:0];
    // The extra top bit holds the true sign, so it selects the clamp side.
    if (sum_ovf && (SAT != 0)) begin
      acc_sum = ((SIGNED != 0) && sum_w[D_W_ACC]) ? ACC_MIN : ACC_MAX;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_a     <= '0;
      bus.out_b     <= '0;
      bus.out_en    <= 1'b0;
      prod_r        <= '0;
      init_r        <= 1'b0;
      en_r          <= 1'b0;
      acc           <= '0;
      ovf           <= 1'b0;
      chain_data    <= '0;
      chain_valid   <= 1'b0;
      chain_ovf     <= 1'b0;
      bus.out_data  <= '0;
      bus.out_valid <= 1'b0;
      bus.out_ovf   <= 1'b0;
    end else begin
      bus.out_a   <= bus.in_a;
      bus.out_b   <= bus.in_b;
      bus.out_en  <= bus.in_en;
      prod_r      <= dot;
      init_r      <= bus.init;
      en_r        <= bus.in_en;
      chain_data  <= bus.in_data;
      chain_valid <= bus.in_valid;
      chain_ovf   <= bus.in_ovf;
      // A local drain takes the output stage; the upstream word there is dropped.
      if (init_r) begin
        bus.out_data  <= acc;
        bus.out_ovf   <= ovf;
        bus.out_valid <= 1'b1;
        acc           <= en_r ? prod_r : '0;
        ovf           <= 1'b0;
      end else begin
        bus.out_data  <= chain_data;
        bus.out_valid <= chain_valid;
        bus.out_ovf   <= chain_ovf;
        if (en_r) begin
          acc <= acc_sum;
          ovf <= ovf | sum_ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_dot_sat.sv
// Bench for pe_dot_sat: four configurations driven with shared stimulus and
// checked each cycle against an arithmetic model of the accumulate/drain rules.
module tb_pe_dot_sat;

  logic        clk = 1'b0;
  logic        vrst;
  logic        vinit, vin_en, vin_valid, vin_ovf;
  logic [15:0] vin_a, vin_b;
  logic [31:0] vin_d;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  // 0: W=32 sat signed, 1: W=20 sat signed, 2: W=20 wrap signed, 3: W=20 sat unsigned
  pe_dot_sat_if #(.D_W(8), .D_W_ACC(32), .LANES(2)) if0 ();
  pe_dot_sat_if #(.D_W(8), .D_W_ACC(20), .LANES(2)) if1 ();
  pe_dot_sat_if #(.D_W(8), .D_W_ACC(20), .LANES(2)) if2 ();
  pe_dot_sat_if #(.D_W(8), .D_W_ACC(20), .LANES(2)) if3 ();

  assign if0.init = vinit;  assign if0.in_en = vin_en;  assign if0.in_a = vin_a;
  assign if0.in_b = vin_b;  assign if0.in_data = vin_d;
  assign if0.in_valid = vin_valid;  assign if0.in_ovf = vin_ovf;
  assign if1.init = vinit;  assign if1.in_en = vin_en;  assign if1.in_a = vin_a;
  assign if1.in_b = vin_b;  assign if1.in_data = vin_d[19:0];
  assign if1.in_valid = vin_valid;  assign if1.in_ovf = vin_ovf;
  assign if2.init = vinit;  assign if2.in_en = vin_en;  assign if2.in_a = vin_a;
  assign if2.in_b = vin_b;  assign if2.in_data = vin_d[19:0];
  assign if2.in_valid = vin_valid;  assign if2.in_ovf = vin_ovf;
  assign if3.init = vinit;  assign if3.in_en = vin_en;  assign if3.in_a = vin_a;
  assign if3.in_b = vin_b;  assign if3.in_data = vin_d[19:0];
  assign if3.in_valid = vin_valid;  assign if3.in_ovf = vin_ovf;

  pe_dot_sat #(.D_W(8), .D_W_ACC(32), .LANES(2), .SAT(1), .SIGNED(1))
    u0 (.clk(clk), .rst(vrst), .bus(if0));
  pe_dot_sat #(.D_W(8), .D_W_ACC(20), .LANES(2), .SAT(1), .SIGNED(1))
    u1 (.clk(clk), .rst(vrst), .bus(if1));
  pe_dot_sat #(.D_W(8), .D_W_ACC(20), .LANES(2), .SAT(0), .SIGNED(1))
    u2 (.clk(clk), .rst(vrst), .bus(if2));
  pe_dot_sat #(.D_W(8), .D_W_ACC(20), .LANES(2), .SAT(1), .SIGNED(0))
    u3 (.clk(clk), .rst(vrst), .bus(if3));

  function automatic int cw(int i);
    return (i == 0) ? 32 : 20;
  endfunction
  function automatic bit csat(int i);
    return i != 2;
  endfunction
  function automatic bit csgn(int i);
    return i != 3;
  endfunction
  function automatic longint mask(int w);
    return (longint'(1) <<< w) - 1;
  endfunction

  function automatic longint dot(bit sgn, logic [15:0] a, logic [15:0] b);
    logic [7:0] la, lb;
    longint s = 0;
    for (int j = 0; j < 2; j++) begin
      la = a[j*8 +: 8];
      lb = b[j*8 +: 8];
      if (sgn) s += longint'($signed(la)) * longint'($signed(lb));
      else     s += longint'(la) * longint'(lb);
    end
    return s;
  endfunction

  // Fit an exact sum into the accumulator range: clamp or wrap, flagging overflow.
  function automatic longint fit(longint s, int w, bit sgn, bit sat, output bit ov);
    longint m, lo, hi, r;
    m  = longint'(1) <<< w;
    lo = sgn ? -(m / 2) : 0;
    hi = sgn ? (m / 2 - 1) : (m - 1);
    ov = (s < lo) || (s > hi);
    if (!ov) return s;
    if (sat) return (s < lo) ? lo : hi;
    r = ((s % m) + m) % m;
    if (sgn && r > hi) r -= m;
    return r;
  endfunction

  // Model state: exact accumulator values plus the inputs from one cycle back.
  longint      m_acc[4];
  bit          m_ovf[4];
  longint      e_data[4];
  bit          e_valid[4], e_ovf[4];
  logic [15:0] e_a = '0, e_b = '0;
  bit          e_en = 0;
  logic [15:0] p_a = '0, p_b = '0;
  logic [31:0] p_d = '0;
  bit          p_en = 0, p_init = 0, p_v = 0, p_o = 0;

  task automatic model_step();
    bit ov;
    for (int i = 0; i < 4; i++) begin
      if (vrst) begin
        m_acc[i] = 0; m_ovf[i] = 0;
        e_data[i] = 0; e_valid[i] = 0; e_ovf[i] = 0;
      end else if (p_init) begin
        e_data[i] = m_acc[i]; e_ovf[i] = m_ovf[i]; e_valid[i] = 1;
        m_acc[i] = p_en ? dot(csgn(i), p_a, p_b) : 0;
        m_ovf[i] = 0;
      end else begin
        e_data[i] = longint'(p_d); e_valid[i] = p_v; e_ovf[i] = p_o;
        if (p_en) begin
          m_acc[i] = fit(m_acc[i] + dot(csgn(i), p_a, p_b), cw(i), csgn(i), csat(i), ov);
          m_ovf[i] = m_ovf[i] | ov;
        end
      end
    end
    e_a    = vrst ? '0 : vin_a;
    e_b    = vrst ? '0 : vin_b;
    e_en   = vrst ? 1'b0 : vin_en;
    p_a    = vrst ? '0 : vin_a;
    p_b    = vrst ? '0 : vin_b;
    p_d    = vrst ? '0 : vin_d;
    p_en   = vrst ? 1'b0 : vin_en;
    p_init = vrst ? 1'b0 : vinit;
    p_v    = vrst ? 1'b0 : vin_valid;
    p_o    = vrst ? 1'b0 : vin_ovf;
  endtask

  task automatic chk(string nm, int i, logic [63:0] got, logic [63:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s inst%0d got %0h want %0h", nm, i, got, want);
    end
  endtask

  task automatic pin(string nm, longint got, longint want);
    vectors++;
    if (got != want) begin
      errors++;
      $display("FAIL pin %s model %0d want %0d", nm, got, want);
    end
  endtask

  task automatic chk_inst(int i, logic [31:0] d, logic v, logic o,
                          logic [15:0] oa, logic [15:0] ob, logic oen);
    chk("out_data",  i, 64'(d), 64'(e_data[i] & mask(cw(i))));
    chk("out_valid", i, 64'(v), 64'(e_valid[i]));
    chk("out_ovf",   i, 64'(o), 64'(e_ovf[i]));
    chk("out_a",     i, 64'(oa), 64'(e_a));
    chk("out_b",     i, 64'(ob), 64'(e_b));
    chk("out_en",    i, 64'(oen), 64'(e_en));
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    chk_inst(0, if0.out_data, if0.out_valid, if0.out_ovf, if0.out_a, if0.out_b, if0.out_en);
    chk_inst(1, 32'(if1.out_data), if1.out_valid, if1.out_ovf, if1.out_a, if1.out_b, if1.out_en);
    chk_inst(2, 32'(if2.out_data), if2.out_valid, if2.out_ovf, if2.out_a, if2.out_b, if2.out_en);
    chk_inst(3, 32'(if3.out_data), if3.out_valid, if3.out_ovf, if3.out_a, if3.out_b, if3.out_en);
  end

  task automatic cyc(input logic [15:0] a, input logic [15:0] b,
                     input logic en, input logic ini, input logic r);
    vin_a = a; vin_b = b; vin_en = en; vinit = ini; vrst = r;
    vin_d = '0; vin_valid = 1'b0; vin_ovf = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      m_acc[i] = 0; m_ovf[i] = 0; e_data[i] = 0; e_valid[i] = 0; e_ovf[i] = 0;
    end
    vrst = 1'b1; vinit = 1'b0; vin_en = 1'b0; vin_a = '0; vin_b = '0;
    vin_d = '0; vin_valid = 1'b0; vin_ovf = 1'b0;
    @(negedge clk);
    repeat (2) cyc(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b1);
    pin("reset_data", e_data[0], 0);
    pin("reset_out_a", longint'(e_a), 0);

    // Basic dot product, 4 enabled cycles of 22
    cyc(16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
    idle();
    repeat (4) cyc(16'h0302, 16'h0405, 1'b1, 1'b0, 1'b0);
    cyc(16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
    pin("basic_not_yet", longint'(e_valid[0]), 0);
    idle();
    pin("basic_data", e_data[0], 88);
    pin("basic_valid", longint'(e_valid[0]), 1);
    pin("basic_ovf", longint'(e_ovf[0]), 0);

    // Signed lanes with stalls
    cyc(16'h8080, 16'h7F80, 1'b1, 1'b0, 1'b0);
    idle();
    cyc(16'h8080, 16'h7F80, 1'b1, 1'b0, 1'b0);
    idle();
    cyc(16'h8080, 16'h7F80, 1'b1, 1'b0, 1'b0);
    cyc(16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
    idle();
    pin("signed_data", e_data[0], 384);
    pin("unsigned_data", e_data[3], 97920);

    // Saturation edge on the 20-bit accumulators
    repeat (16) cyc(16'h7F7F, 16'h7F7F, 1'b1, 1'b0, 1'b0);
    cyc(16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
    idle();
    pin("sat16_data", e_data[1], 516128);
    pin("sat16_ovf", longint'(e_ovf[1]), 0);
    repeat (17) cyc(16'h7F7F, 16'h7F7F, 1'b1, 1'b0, 1'b0);
    cyc(16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
    idle();
    pin("sat17_data", e_data[1], 524287);
    pin("sat17_ovf", longint'(e_ovf[1]), 1);
    pin("wrap17_data", e_data[2], -500190);
    pin("wrap17_ovf", longint'(e_ovf[2]), 1);
    pin("wide17_data", e_data[0], 548386);

    // Drain chain pass-through
    vin_a = '0; vin_b = '0; vin_en = 1'b0; vinit = 1'b0; vrst = 1'b0;
    vin_d = 32'h1234; vin_valid = 1'b1; vin_ovf = 1'b1;
    @(negedge clk);
    idle();
    pin("chain_data", e_data[0], 32'h1234);
    pin("chain_valid", longint'(e_valid[0]), 1);
    pin("chain_ovf", longint'(e_ovf[0]), 1);
    idle();
    pin("chain_idle", longint'(e_valid[0]), 0);

    // Back-to-back init
    repeat (4) cyc(16'h0302, 16'h0405, 1'b1, 1'b0, 1'b0);
    cyc(16'h0302, 16'h0405, 1'b1, 1'b1, 1'b0);
    cyc(16'h0302, 16'h0405, 1'b1, 1'b1, 1'b0);
    pin("b2b_first", e_data[0], 88);
    idle();
    pin("b2b_second", e_data[0], 22);
    idle();
    pin("b2b_acc", m_acc[0], 22);

    // Reset in the middle of an accumulation
    repeat (3) cyc(16'h0302, 16'h0405, 1'b1, 1'b0, 1'b0);
    cyc(16'h0302, 16'h0405, 1'b1, 1'b0, 1'b1);
    pin("rst_mid_out_a", longint'(e_a), 0);
    cyc(16'h0302, 16'h0405, 1'b0, 1'b1, 1'b0);
    idle();
    pin("rst_mid_data", e_data[0], 0);
    pin("rst_mid_valid", longint'(e_valid[0]), 1);
    pin("rst_mid_ovf", longint'(e_ovf[0]), 0);

    // Random traffic, operands biased toward extremes to reach overflow
    for (int n = 0; n < 3000; n++) begin
      vrst      = ($urandom_range(99) == 0);
      vinit     = ($urandom_range(15) == 0);
      vin_en    = ($urandom_range(3) != 0);
      vin_a     = ($urandom_range(1) == 0) ? 16'h7F80 : 16'($urandom);
      vin_b     = ($urandom_range(1) == 0) ? 16'h7F80 : 16'($urandom);
      vin_d     = $urandom;
      vin_valid = $urandom_range(1) == 1;
      vin_ovf   = $urandom_range(1) == 1;
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
